// File: rtl/i2d_if.sv
// ---------------------------------------------------------------------------
// i2d_if : instruction fetch stage of the i2d core.
//
// Owns the program counter and fetches one 32-bit word at a time over a
// req/ack instruction bus. The fetched word and its address go to decode
// through registered outputs. A one-entry skid buffer absorbs decode stalls.
// Taken branches from later stages redirect the fetch stream. A request that
// is still in flight at the redirect finishes in DRAIN, and its data is
// dropped there.
//
// Parameters
//   RESET_PC       first fetch address after reset (word aligned)
//   NOP_INS        instruction word presented during bubbles
// Ports
//   clk            core clock, rising edge
//   rst            synchronous active-high reset
//   ibus_req/addr  fetch request and address (address stable until ack)
//   ibus_ack       fetch complete; ibus_data / ibus_err valid with it
//   if_halt        decode stall, freezes if_ins / if_pc / if_valid
//   branch_taken   single-cycle redirect to branch_target
//   if_ins/if_pc   registered instruction and its address
//   if_valid       if_ins holds a real instruction
//   if_err         sticky fault (bus error or misaligned branch target)
// ---------------------------------------------------------------------------
module i2d_if #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        ibus_req,
  output logic [31:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_data,
  input  logic        ibus_err,
  input  logic        if_halt,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic        if_valid,
  output logic        if_err
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ERR   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] stale_addr_q, stale_addr_d;
  logic        pend_err_q, pend_err_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_ins_q, skid_ins_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] if_ins_q, if_ins_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        if_valid_q, if_valid_d;
  logic        if_err_q, if_err_d;

  logic        accept;
  logic        misaligned;

  // The request is combinational on state and skid occupancy. It drops the
  // same cycle the skid fills and rises again the cycle the skid drains.
  // It is also forced low while reset is held, so a pending request is
  // withdrawn immediately.
  always_comb begin
    ibus_req  = !rst && (((state_q == ST_FETCH) && !skid_valid_q) ||
                         (state_q == ST_DRAIN));
    ibus_addr = (state_q == ST_DRAIN) ? stale_addr_q : pc_q;
  end

  assign accept     = ibus_req && ibus_ack;
  assign misaligned = (branch_target[1:0] != 2'b00);

  // Next-state logic.
  // Order of precedence: a branch always wins. Within FETCH, an accepted bus
  // error beats halt handling. A skid refill and a new accept never happen in
  // the same cycle, because no request is made while the skid is full.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    stale_addr_d = stale_addr_q;
    pend_err_d   = pend_err_q;
    skid_valid_d = skid_valid_q;
    skid_ins_d   = skid_ins_q;
    skid_pc_d    = skid_pc_q;
    if_ins_d     = if_ins_q;
    if_pc_d      = if_pc_q;
    if_valid_d   = if_valid_q;
    if_err_d     = if_err_q;

    if (branch_taken) begin
      skid_valid_d = 1'b0;
      if_valid_d   = 1'b0;
      if_ins_d     = NOP_INS;
      pc_d         = branch_target;
      // A misaligned target is flagged at once. A later aligned branch
      // (from DRAIN or ERR) clears the flag again.
      if_err_d     = misaligned;
      if (misaligned) begin
        if_pc_d = branch_target;
      end
      if (ibus_req && !ibus_ack) begin
        // Finish the outstanding request first. The address stays on the
        // bus, and the returned word is thrown away.
        state_d      = ST_DRAIN;
        stale_addr_d = ibus_addr;
        pend_err_d   = misaligned;
      end else if (misaligned) begin
        state_d = ST_ERR;
      end else begin
        state_d = ST_FETCH;
      end
    end else begin
      unique case (state_q)
        ST_FETCH: begin
          if (accept && ibus_err) begin
            state_d    = ST_ERR;
            if_err_d   = 1'b1;
            if_pc_d    = pc_q;
            if_valid_d = 1'b0;
            if_ins_d   = NOP_INS;
          end else begin
            if (accept) begin
              pc_d = pc_q + 32'd4;
            end
            if (if_halt) begin
              if (accept) begin
                skid_valid_d = 1'b1;
                skid_ins_d   = ibus_data;
                skid_pc_d    = pc_q;
              end
            end else if (skid_valid_q) begin
              skid_valid_d = 1'b0;
              if_ins_d     = skid_ins_q;
              if_pc_d      = skid_pc_q;
              if_valid_d   = 1'b1;
            end else if (accept) begin
              if_ins_d   = ibus_data;
              if_pc_d    = pc_q;
              if_valid_d = 1'b1;
            end else begin
              // No new data while decode is running: bubble, and if_pc holds.
              if_ins_d   = NOP_INS;
              if_valid_d = 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          // A bus error on the stale fetch is ignored.
          if (ibus_ack) begin
            state_d = pend_err_q ? ST_ERR : ST_FETCH;
          end
        end
        ST_ERR: begin
          state_d = ST_ERR;
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_FETCH;
      pc_q         <= RESET_PC;
      stale_addr_q <= RESET_PC;
      pend_err_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_ins_q   <= NOP_INS;
      skid_pc_q    <= 32'h0000_0000;
      if_ins_q     <= NOP_INS;
      if_pc_q      <= 32'h0000_0000;
      if_valid_q   <= 1'b0;
      if_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      stale_addr_q <= stale_addr_d;
      pend_err_q   <= pend_err_d;
      skid_valid_q <= skid_valid_d;
      skid_ins_q   <= skid_ins_d;
      skid_pc_q    <= skid_pc_d;
      if_ins_q     <= if_ins_d;
      if_pc_q      <= if_pc_d;
      if_valid_q   <= if_valid_d;
      if_err_q     <= if_err_d;
    end
  end

  assign if_ins   = if_ins_q;
  assign if_pc    = if_pc_q;
  assign if_valid = if_valid_q;
  assign if_err   = if_err_q;

endmodule

// File: tb/tb_i2d_if.sv
// ---------------------------------------------------------------------------
// tb_i2d_if : directed self-checking bench for the i2d_if fetch stage.
// The bus model returns the fetch address as the instruction word. It acks
// either at zero wait (auto mode) or under manual control, and it can inject
// a bus error on the next ack.
// ---------------------------------------------------------------------------
module tb_i2d_if;

  logic        clk;
  logic        rst;
  logic        ibus_req;
  logic [31:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_data;
  logic        ibus_err;
  logic        if_halt;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_ins;
  logic [31:0] if_pc;
  logic        if_valid;
  logic        if_err;

  logic        bus_auto;
  logic        man_ack;
  logic        err_inj;

  int          check_count;
  int          fail_count;

  i2d_if #(
    .RESET_PC (32'h0000_0000),
    .NOP_INS  (32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .ibus_req      (ibus_req),
    .ibus_addr     (ibus_addr),
    .ibus_ack      (ibus_ack),
    .ibus_data     (ibus_data),
    .ibus_err      (ibus_err),
    .if_halt       (if_halt),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .if_ins        (if_ins),
    .if_pc         (if_pc),
    .if_valid      (if_valid),
    .if_err        (if_err)
  );

  // Bus responder: the data word is the fetch address itself.
  assign ibus_ack  = bus_auto ? ibus_req : (man_ack && ibus_req);
  assign ibus_data = ibus_addr;
  assign ibus_err  = err_inj && ibus_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic halt, input logic br,
                               input logic [31:0] tgt);
    if_halt       = halt;
    branch_taken  = br;
    branch_target = tgt;
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkValid(input string tag, input logic [31:0] pc);
    checkOutput({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
    checkOutput({tag, "_pc"},    if_pc, pc);
    checkOutput({tag, "_ins"},   if_ins, pc);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    fail_count++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    check_count = 0;
    fail_count  = 0;
    rst      = 1'b1;
    bus_auto = 1'b1;
    man_ack  = 1'b0;
    err_inj  = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);

    // Reset values
    tick();
    tick();
    checkOutput("rst_req",   {31'd0, ibus_req}, 32'd0);
    checkOutput("rst_addr",  ibus_addr, 32'h0);
    checkOutput("rst_ins",   if_ins, 32'h0);
    checkOutput("rst_pc",    if_pc, 32'h0);
    checkOutput("rst_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_err",   {31'd0, if_err}, 32'd0);

    // Zero-wait streaming
    rst = 1'b0;
    #1;
    checkOutput("first_req",  {31'd0, ibus_req}, 32'd1);
    checkOutput("first_addr", ibus_addr, 32'h0);
    tick(); checkValid("s0", 32'h0);
    tick(); checkValid("s4", 32'h4);
    tick(); checkValid("s8", 32'h8);
    tick(); checkValid("s12", 32'hC);

    // Halt for three edges: one word goes into the skid, then requests stop
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("h1_req", {31'd0, ibus_req}, 32'd0);
    checkValid("h1", 32'hC);
    tick();
    checkOutput("h2_req", {31'd0, ibus_req}, 32'd0);
    checkValid("h2", 32'hC);
    tick();
    checkOutput("h3_req", {31'd0, ibus_req}, 32'd0);
    checkValid("h3", 32'hC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkValid("rel16", 32'h10);
    checkOutput("rel_req",  {31'd0, ibus_req}, 32'd1);
    checkOutput("rel_addr", ibus_addr, 32'h14);
    tick(); checkValid("rel20", 32'h14);
    tick(); checkValid("rel24", 32'h18);

    // Branch to 0x8 with the current fetch acked: that word is dropped
    applyStimulus(1'b0, 1'b1, 32'h8);
    tick();
    checkOutput("b8_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("b8_ins",   if_ins, 32'h0);
    checkOutput("b8_addr",  ibus_addr, 32'h8);
    // Fetch of 0x8 stalls on the bus, then branch to 0x100 arrives
    bus_auto = 1'b0;
    man_ack  = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("w1_addr", ibus_addr, 32'h8);
    applyStimulus(1'b0, 1'b1, 32'h100);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("dr_req",   {31'd0, ibus_req}, 32'd1);
    checkOutput("dr_addr",  ibus_addr, 32'h8);
    checkOutput("dr_valid", {31'd0, if_valid}, 32'd0);
    tick();
    checkOutput("dr2_addr",  ibus_addr, 32'h8);
    checkOutput("dr2_valid", {31'd0, if_valid}, 32'd0);
    man_ack = 1'b1;
    tick();
    man_ack  = 1'b0;
    bus_auto = 1'b1;
    checkOutput("tg_addr",  ibus_addr, 32'h100);
    checkOutput("tg_valid", {31'd0, if_valid}, 32'd0);
    tick(); checkValid("t100", 32'h100);
    tick(); checkValid("t104", 32'h104);

    // Misaligned branch target, then recovery
    applyStimulus(1'b0, 1'b1, 32'h102);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("mis_err",   {31'd0, if_err}, 32'd1);
    checkOutput("mis_pc",    if_pc, 32'h102);
    checkOutput("mis_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("mis_req",   {31'd0, ibus_req}, 32'd0);
    tick();
    checkOutput("mis_req2",  {31'd0, ibus_req}, 32'd0);
    checkOutput("mis_err2",  {31'd0, if_err}, 32'd1);
    applyStimulus(1'b0, 1'b1, 32'h200);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("rec_err",  {31'd0, if_err}, 32'd0);
    checkOutput("rec_req",  {31'd0, ibus_req}, 32'd1);
    checkOutput("rec_addr", ibus_addr, 32'h200);
    tick(); checkValid("t200", 32'h200);

    // Bus error on the fetch of 0x10
    applyStimulus(1'b0, 1'b1, 32'h10);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    err_inj = 1'b1;
    tick();
    err_inj = 1'b0;
    checkOutput("be_err",   {31'd0, if_err}, 32'd1);
    checkOutput("be_pc",    if_pc, 32'h10);
    checkOutput("be_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("be_req",   {31'd0, ibus_req}, 32'd0);
    tick();
    checkOutput("be_req2",  {31'd0, ibus_req}, 32'd0);

    // Skid full, then branch and halt in the same cycle; then wrap past 2^32
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hb_err", {31'd0, if_err}, 32'd0);
    tick(); checkValid("tF8", 32'hFFFF_FFF8);
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("hb_skid_req", {31'd0, ibus_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'hFFFF_FFF0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("hb_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("hb_ins",   if_ins, 32'h0);
    checkOutput("hb_req",   {31'd0, ibus_req}, 32'd1);
    checkOutput("hb_addr",  ibus_addr, 32'hFFFF_FFF0);
    tick(); checkValid("wF0", 32'hFFFF_FFF0);
    tick(); checkValid("wF4", 32'hFFFF_FFF4);
    tick(); checkValid("wF8", 32'hFFFF_FFF8);
    tick(); checkValid("wFC", 32'hFFFF_FFFC);
    checkOutput("wrap_addr", ibus_addr, 32'h0);
    tick(); checkValid("w00", 32'h0);
    tick(); checkValid("w04", 32'h4);

    // Reset in the middle of a stalled request
    bus_auto = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checkOutput("mr_req_withdraw", {31'd0, ibus_req}, 32'd0);
    tick();
    checkOutput("mr_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("mr_pc",    if_pc, 32'h0);
    checkOutput("mr_addr",  ibus_addr, 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("mr_req", {31'd0, ibus_req}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/i2d_if.md
# i2d_if

Instruction fetch stage of the i2d core: owns the program counter, issues word fetches on the instruction bus with a req/ack handshake, and presents `if_ins`/`if_pc` to the decode stage. Sits directly upstream of decode; absorbs decode back-pressure with a one-entry skid buffer and redirects on taken branches from later stages, discarding stale in-flight fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset (must be word-aligned)
- `NOP_INS`, 32'h0000_0000, instruction word driven on `if_ins` during bubbles
- `clk`  in  1  core clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `ibus_req`  out  1  fetch request; held until acked
- `ibus_addr`  out  32  fetch address; stable while `ibus_req` && !`ibus_ack`
- `ibus_ack`  in  1  fetch complete this cycle; may be asserted in the cycle `ibus_req` rises
- `ibus_data`  in  32  instruction word, valid with `ibus_ack`
- `ibus_err`  in  1  bus fault, valid with `ibus_ack`
- `if_halt`  in  1  decode stall: hold `if_ins`/`if_pc`/`if_valid`
- `branch_taken`  in  1  single-cycle redirect request
- `branch_target`  in  32  redirect address, valid with `branch_taken`
- `if_ins`  out  32  registered instruction to decode
- `if_pc`  out  32  registered address of `if_ins`
- `if_valid`  out  1  `if_ins` holds a real instruction
- `if_err`  out  1  sticky fetch fault (bus error or misaligned target)

## Operation
- States: FETCH (issue/continue requests), DRAIN (one stale request outstanding, result discarded), ERR (halted on fault).
- `pc` register = next address to fetch; `ibus_addr` = `pc` in FETCH, latched stale address in DRAIN.
- `ibus_req` = (FETCH && !`skid_valid`) || DRAIN; 0 in ERR.
- Accepted fetch (FETCH, req && ack && !err): `pc` <= `pc`+4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0). If !`if_halt` and skid empty: `if_ins`<=data, `if_pc`<=address, `if_valid`<=1. If `if_halt`: word goes to skid buffer.
- Halt released with skid full: skid moves to output registers, skid empties, `ibus_req` reasserts same cycle skid clears (comb on `skid_valid`).
- Halt released, no new data: `if_valid`<=0, `if_ins`<=`NOP_INS` (bubble); `if_pc` holds.
- Priority: `rst` > `branch_taken` > `ibus_err` > `if_halt`.
- `branch_taken` (any state but reset): skid cleared; `if_valid`<=0, `if_ins`<=`NOP_INS` next cycle regardless of `if_halt`; `pc`<=`branch_target`.
  - Request outstanding and not acked this cycle -> DRAIN, holding old address until ack; acked word dropped, then FETCH at target.
  - Acked this cycle -> word dropped, FETCH at target next cycle.
  - `branch_target[1:0]` != 0 -> ERR, `if_pc`<=`branch_target`, `if_err`<=1 (if a request is outstanding, complete it via DRAIN first, then ERR).
  - Branch in DRAIN replaces the pending target; still one discard.
  - Branch in ERR with aligned target clears `if_err`, resumes FETCH.
- `ibus_err` with ack in FETCH -> ERR, `if_err`<=1, `if_pc`<=faulting address, `if_valid`<=0. `ibus_err` during DRAIN ignored (stale).

## Timing
- Reset values: `ibus_req`=0, `ibus_addr`=`RESET_PC`, `if_ins`=`NOP_INS`, `if_pc`=0, `if_valid`=0, `if_err`=0, `pc`=`RESET_PC`, skid empty, state FETCH.
- First cycle after `rst` falls: `ibus_req`=1, `ibus_addr`=`RESET_PC`.
- Latency ack -> `if_valid`: 1 clock (registered). Zero-wait bus: one instruction per cycle, back-to-back.
- Redirect latency: `branch_taken` at cycle N -> bubble at N+1; zero-wait bus: target request at N+1, target instruction valid at N+2.
- `rst` mid-request: all state reset; bus must tolerate request withdrawal.

## Test plan
- Reset, zero-wait bus returning addr as data: `if_pc` = 0,4,8,12 on consecutive cycles, `if_valid`=1 from 2nd cycle after reset.
- `if_halt` high 3 cycles during streaming: outputs frozen, exactly one extra word in skid, `ibus_req`=0 while full; release -> sequence resumes with no lost/duplicated PC.
- `branch_taken` to 0x100 while a 3-wait-state fetch of 0x8 is pending: `ibus_addr` holds 0x8 until ack, word dropped, next `if_pc`=0x100, no 0x8/0xC on `if_pc` with `if_valid`=1.
- Branch to 0x102: `if_err`=1, `if_pc`=0x102, `ibus_req`=0 thereafter; later branch to 0x200 clears `if_err`, fetch resumes at 0x200.
- `ibus_err` on fetch of 0x10: `if_err`=1, `if_pc`=0x10, `if_valid`=0, no further requests.
- `branch_taken` and `if_halt` same cycle with skid full: skid discarded, bubble, next valid `if_pc`=target; PC wrap from 0xFFFF_FFFC fetches 0x0.
